// File: rtl/audio_frame_buffer.sv
// audio_frame_buffer: pre-emphasises incoming 16-bit PCM samples, stores them in a
// ring buffer and streams overlapping frames (FRAME_LEN samples, HOP_LEN advance)
// to the MFCC engine.
//
// Output handshake: a beat transfers on a rising edge where frame_valid && frame_ready.
// While frame_valid is high and frame_ready is low, frame_sample/first/last hold.
// frame_valid only drops mid-frame on flush (enable=0) or reset.
module audio_frame_buffer #(
  parameter int FRAME_LEN   = 256,
  parameter int HOP_LEN     = 128,
  parameter int ALPHA_SHIFT = 5,
  parameter int DEPTH       = FRAME_LEN + HOP_LEN
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] audio_sample,
  input  logic        sample_valid,
  output logic [15:0] frame_sample,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        frame_first,
  output logic        frame_last,
  output logic [15:0] frame_count,
  output logic        overflow,
  output logic [1:0]  o_dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW:0]   DEPTH_P = (PW+1)'(DEPTH);
  localparam logic [PW:0]   HOP_P   = (PW+1)'(HOP_LEN);
  localparam logic [PW:0]   ONE_P   = (PW+1)'(1);
  localparam logic [CW-1:0] FRAME_C = CW'(FRAME_LEN);
  localparam logic [CW-1:0] HOP_C   = CW'(HOP_LEN);
  localparam logic [CW-1:0] LAST_C  = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [15:0]   r_mem [DEPTH];
  logic [15:0]   r_x_prev;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_base;
  logic [CW-1:0] r_fill;
  logic [CW-1:0] r_pend;
  logic [CW-1:0] r_beat;
  logic [15:0]   r_sample;
  logic          r_valid;
  logic          r_first;
  logic          r_last;
  logic [15:0]   r_count;
  logic          r_overflow;

  logic signed [17:0] w_x_ext;
  logic signed [17:0] w_p_ext;
  logic signed [17:0] w_y_ext;
  logic [15:0]        w_y_sat;
  logic               w_accept;
  logic               w_drop;
  logic               w_hs;
  logic               w_done;
  logic               w_load;
  logic [CW-1:0]      w_fill_next;
  logic [CW-1:0]      w_pend_next;
  logic [PW-1:0]      w_rd_addr;

  // Ring-buffer address add; both operands are below DEPTH so one subtract suffices.
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] a, input logic [PW:0] b);
    logic [PW:0] s;
    s = {1'b0, a} + b;
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PW-1:0];
  endfunction

  // Pre-emphasis y = x - x_prev + (x_prev >>> ALPHA_SHIFT) at 18 bits, saturated to 16.
  always_comb begin
    w_x_ext = {{2{audio_sample[15]}}, audio_sample};
    w_p_ext = {{2{r_x_prev[15]}}, r_x_prev};
    w_y_ext = w_x_ext - w_p_ext + (w_p_ext >>> ALPHA_SHIFT);
    if (w_y_ext > 18'sd32767)       w_y_sat = 16'h7fff;
    else if (w_y_ext < -18'sd32768) w_y_sat = 16'h8000;
    else                            w_y_sat = w_y_ext[15:0];
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_FILL;
    else        r_state <= w_state_next;
  end

  // Next-state logic; a frame only starts once its newest sample is already written.
  always_comb begin
    w_state_next = r_state;
    if (!enable) begin
      w_state_next = ST_FILL;
    end else begin
      case (r_state)
        ST_FILL:   if (w_fill_next == FRAME_C) w_state_next = ST_STREAM;
        ST_WAIT:   if (w_pend_next == HOP_C)   w_state_next = ST_STREAM;
        ST_STREAM: if (w_done) w_state_next = (w_pend_next >= HOP_C) ? ST_STREAM : ST_WAIT;
        default:   w_state_next = ST_FILL;
      endcase
    end
  end

  // FSM outputs: accept/drop decisions and read-side strobes.
  always_comb begin
    w_accept = 1'b0;
    w_drop   = 1'b0;
    w_done   = 1'b0;
    w_load   = 1'b0;
    w_hs     = r_valid && frame_ready;
    if (enable && sample_valid) begin
      // A full hop is already waiting behind the current frame: no room left.
      if (r_state == ST_STREAM && r_pend == HOP_C) w_drop = 1'b1;
      else                                         w_accept = 1'b1;
    end
    if (enable && r_state == ST_STREAM) begin
      w_done = w_hs && r_last;
      w_load = (!r_valid && r_beat == '0) || (w_hs && !r_last);
    end
    w_fill_next = r_fill + CW'(w_accept);
    w_pend_next = r_pend + CW'(w_accept);
    w_rd_addr   = wrap_add(r_base, (PW+1)'(r_beat));
    o_dbg_state = r_state;
  end

  // Sample storage; no reset needed, contents are only read after being written.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= w_y_sat;
  end

  // Datapath: write side counters, frame pointer and the registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x_prev   <= '0;
      r_wr_ptr   <= '0;
      r_base     <= '0;
      r_fill     <= '0;
      r_pend     <= '0;
      r_beat     <= '0;
      r_sample   <= '0;
      r_valid    <= 1'b0;
      r_first    <= 1'b0;
      r_last     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_done) r_count <= r_count + 16'd1;
      if (!enable) begin
        // Flush: abandon any partial frame, keep frame_count and overflow.
        r_x_prev <= '0;
        r_wr_ptr <= '0;
        r_base   <= '0;
        r_fill   <= '0;
        r_pend   <= '0;
        r_beat   <= '0;
        r_sample <= '0;
        r_valid  <= 1'b0;
        r_first  <= 1'b0;
        r_last   <= 1'b0;
      end else begin
        if (w_accept) begin
          r_wr_ptr <= wrap_add(r_wr_ptr, ONE_P);
          r_x_prev <= audio_sample;
        end
        if (r_state == ST_FILL) r_fill <= (w_state_next == ST_STREAM) ? '0 : w_fill_next;
        case (r_state)
          ST_WAIT:   r_pend <= (w_state_next == ST_STREAM) ? '0 : w_pend_next;
          ST_STREAM: r_pend <= (w_done && w_pend_next >= HOP_C) ? (w_pend_next - HOP_C)
                                                                  : w_pend_next;
          default:   r_pend <= '0;
        endcase
        // The next frame starts HOP_LEN entries later; advance as this one completes.
        if (r_state == ST_FILL) r_base <= '0;
        else if (w_done)        r_base <= wrap_add(r_base, HOP_P);
        if (w_load) begin
          r_sample <= r_mem[w_rd_addr];
          r_valid  <= 1'b1;
          r_first  <= (r_beat == '0);
          r_last   <= (r_beat == LAST_C);
          r_beat   <= r_beat + ONE_C;
        end else if (w_done) begin
          r_valid <= 1'b0;
          r_first <= 1'b0;
          r_last  <= 1'b0;
          r_beat  <= '0;
        end
      end
    end
  end

  assign frame_sample = r_sample;
  assign frame_valid  = r_valid;
  assign frame_first  = r_first;
  assign frame_last   = r_last;
  assign frame_count  = r_count;
  assign overflow     = r_overflow;

endmodule
